qspi_flash_rd_seq: RTL
======================

// Module: qspi_flash_rd_seq
// PURPOSE
//  Upstream master for qspi_wrap: turns one flash read command (24b addr, byte count) into the
//  register-access sequence on qspi_if_req/rsp (CS assert, opcode, address, optional dummy, data
//  reads, CS deassert). Read bytes leave on a valid/ready byte stream. One wrap transaction in flight.
// PARAMETERS
//  DIV     4'd1   SCK divider, written to config1[7:4]
//  MODE    2'b00  SPI mode, written to config0[7:6]
//  LEN_W   16     width of byte-count field
// PORTS
//  clk              in   1      clock
//  rst_n            in   1      asynchronous active-low reset
//  rd_req_vld       in   1      read command valid
//  rd_req_rdy       out  1      command accepted when vld&rdy; high only in IDLE
//  rd_req_addr      in   24     flash byte address
//  rd_req_len       in   LEN_W  bytes to read; 0 = no bus traffic
//  rd_req_quad      in   1      0: opcode 0x03 single; 1: opcode 0x6B quad-out + 8 dummy clocks
//  out_vld          out  1      read byte valid
//  out_rdy          in   1      consumer ready
//  out_dat          out  8      read byte
//  rd_done          out  1      1-cycle pulse after CS deasserted (or len==0 accept)
//  qspi_if_req_vld  out  1      to wrap: register access valid
//  qspi_if_req_rdy  in   1      from wrap
//  qspi_if_req_addr out  3      0 config0, 1 config1, 2 data
//  qspi_if_req_read out  1      1 = data read
//  qspi_if_req_dat  out  8      write data
//  qspi_if_rsp_vld  in   1      from wrap
//  qspi_if_rsp_rdy  out  1      to wrap
//  qspi_if_rsp_dat  in   8      read data
// BEHAVIOUR
//  Reset: state IDLE; rd_req_rdy=1; qspi_if_req_vld, qspi_if_rsp_rdy, out_vld, rd_done = 0; counters 0.
//  Encodings: config0={MODE,dummy,type[1:0],duxen=0,2'b00}; type 00 single, 10 quad.
//   config1={DIV,csn,3'b000}; csn=0 asserts chip select.
//  Every access = ISSUE then RESP: ISSUE holds req_vld and stable addr/read/dat until req_rdy;
//   next cycle RESP holds rsp_rdy. Write RESP: rsp_rdy=1, advance on rsp_vld. Never a new ISSUE before
//   previous response consumed.
//  Accept: latch addr, len, quad. len==0 -> rd_done next cycle, back to IDLE, no wrap traffic.
//  States (each one ISSUE/RESP pair):
//   CS_ON   wr cfg1 {DIV,0,000}
//   CFG_CMD wr cfg0 {MODE,0,00,0,00}
//   CMD     wr data 0x03 / 0x6B
//   A2,A1,A0 wr data addr[23:16],[15:8],[7:0]
//   DMY     quad only: wr cfg0 dummy=1, then wr data 0x00 (8 SCK)
//   CFG_DAT wr cfg0 type = quad?10:00, dummy=0
//   RD      rd data; RESP: out_vld=rsp_vld, out_dat=rsp_dat, rsp_rdy=out_rdy (zero-latency pass-through,
//           no buffering); on rsp_vld&out_rdy decrement remaining; 0 -> CS_OFF else next ISSUE
//   CS_OFF  wr cfg1 {DIV,1,000}; on response -> DONE
//   DONE    rd_done=1 one cycle -> IDLE
//  out_vld only asserted in RD/RESP; out_dat only meaningful with out_vld.
//  Remaining counter LEN_W bits; max len 2^LEN_W-1; address not incremented internally (flash does it).
//  out_rdy low stalls RD indefinitely; CS stays asserted, no timeout.
//  rd_req_vld ignored outside IDLE; new command accepted the cycle after rd_done.
//  Reset mid-op: immediate return to IDLE, outputs to reset values; wrap reset shared, CS released.
// TESTING
//  1 single, addr 0x123456 len 2 -> cfg1 0x10(DIV=1), cfg0 0x00, data 0x03,0x12,0x34,0x56, 2 reads, cfg1 0x18, rd_done.
//  2 quad, addr 0x000010 len 1 -> after addr: cfg0 0x20, data 0x00, cfg0 0x10, 1 read, byte 0xA5 on out_dat.
//  3 len 0 -> no qspi_if_req_vld ever, rd_done 1 cycle after accept, rd_req_rdy back high.
//  4 out_rdy low 20 cycles mid-read -> out_vld held, out_dat stable, qspi_if_rsp_rdy 0, no new req.
//  5 qspi_if_req_rdy/rsp_vld random stalls -> req fields stable while vld&!rdy; exact byte order kept.
//  6 rst_n low during A1 -> all outputs reset values; next command runs full sequence from CS_ON.

Source files
------------

// File: rtl/qspi_flash_rd_seq.sv
// Flash read sequencer: expands one read command into the config/data register accesses
// on the qspi_wrap request/response port and streams the returned bytes out.
module qspi_flash_rd_seq #(
  parameter logic [3:0]  DIV   = 4'd1,
  parameter logic [1:0]  MODE  = 2'b00,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req_vld,
  output logic             rd_req_rdy,
  input  logic [23:0]      rd_req_addr,
  input  logic [LEN_W-1:0] rd_req_len,
  input  logic             rd_req_quad,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [7:0]       out_dat,
  output logic             rd_done,
  output logic             qspi_if_req_vld,
  input  logic             qspi_if_req_rdy,
  output logic [2:0]       qspi_if_req_addr,
  output logic             qspi_if_req_read,
  output logic [7:0]       qspi_if_req_dat,
  input  logic             qspi_if_rsp_vld,
  output logic             qspi_if_rsp_rdy,
  input  logic [7:0]       qspi_if_rsp_dat
);

  localparam logic [2:0] RegCfg0 = 3'd0;
  localparam logic [2:0] RegCfg1 = 3'd1;
  localparam logic [2:0] RegData = 3'd2;

  typedef enum logic [3:0] {
    StIdle, StCsOn, StCfgCmd, StCmd, StA2, StA1, StA0,
    StDmyCfg, StDmyDat, StCfgDat, StRd, StCsOff, StDone
  } state_e;

  state_e           state_q, state_d;
  logic             resp_q, resp_d;  // 0: ISSUE phase, 1: RESP phase of current access
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             quad_q, quad_d;
  logic             busy;

  function automatic logic [7:0] cfg0(input logic dummy, input logic [1:0] typ);
    return {MODE, dummy, typ, 1'b0, 2'b00};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      resp_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      quad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      quad_q  <= quad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    quad_d  = quad_q;
    case (state_q)
      StIdle: begin
        if (rd_req_vld) begin
          addr_d  = rd_req_addr;
          rem_d   = rd_req_len;
          quad_d  = rd_req_quad;
          resp_d  = 1'b0;
          state_d = (rd_req_len == '0) ? StDone : StCsOn;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (!resp_q) begin
          if (qspi_if_req_rdy) resp_d = 1'b1;
        end else if (qspi_if_rsp_vld && qspi_if_rsp_rdy) begin
          resp_d = 1'b0;
          case (state_q)
            StCsOn:   state_d = StCfgCmd;
            StCfgCmd: state_d = StCmd;
            StCmd:    state_d = StA2;
            StA2:     state_d = StA1;
            StA1:     state_d = StA0;
            StA0:     state_d = quad_q ? StDmyCfg : StCfgDat;
            StDmyCfg: state_d = StDmyDat;
            StDmyDat: state_d = StCfgDat;
            StCfgDat: state_d = StRd;
            StRd: begin
              rem_d   = rem_q - LEN_W'(1);
              state_d = (rem_q == LEN_W'(1)) ? StCsOff : StRd;
            end
            StCsOff:  state_d = StDone;
            default:  state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  assign busy = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    rd_req_rdy       = (state_q == StIdle);
    rd_done          = (state_q == StDone);
    qspi_if_req_vld  = busy && !resp_q;
    // Read data passes straight through: backpressure from the consumer reaches the wrap.
    qspi_if_rsp_rdy  = busy && resp_q && ((state_q == StRd) ? out_rdy : 1'b1);
    out_vld          = (state_q == StRd) && resp_q && qspi_if_rsp_vld;
    out_dat          = qspi_if_rsp_dat;
    qspi_if_req_addr = RegData;
    qspi_if_req_read = 1'b0;
    qspi_if_req_dat  = 8'h00;
    case (state_q)
      StCsOn: begin
        qspi_if_req_addr = RegCfg1;
        qspi_if_req_dat  = {DIV, 1'b0, 3'b000};
      end
      StCfgCmd: begin
        qspi_if_req_addr = RegCfg0;
        qspi_if_req_dat  = cfg0(1'b0, 2'b00);
      end
      StCmd:    qspi_if_req_dat = quad_q ? 8'h6B : 8'h03;
      StA2:     qspi_if_req_dat = addr_q[23:16];
      StA1:     qspi_if_req_dat = addr_q[15:8];
      StA0:     qspi_if_req_dat = addr_q[7:0];
      StDmyCfg: begin
        qspi_if_req_addr = RegCfg0;
        qspi_if_req_dat  = cfg0(1'b1, 2'b00);
      end
      StDmyDat: qspi_if_req_dat = 8'h00;
      StCfgDat: begin
        qspi_if_req_addr = RegCfg0;
        qspi_if_req_dat  = cfg0(1'b0, quad_q ? 2'b10 : 2'b00);
      end
      StRd:     qspi_if_req_read = 1'b1;
      StCsOff: begin
        qspi_if_req_addr = RegCfg1;
        qspi_if_req_dat  = {DIV, 1'b1, 3'b000};
      end
      default: ;
    endcase
  end

endmodule
